// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 multiplier across N_REQ requesters,
// with a 2-stage operand/result pipeline. Define FP_MUL_ARB_STATS_EN to add grant/stall counters.

// FP32 multiply: round-to-nearest-even, subnormal inputs/outputs flushed to signed zero.
module fp_mul (
   input  logic [31:0] in1,
   input  logic [31:0] in2,
   output logic [31:0] out
);
   localparam logic [31:0] QNAN = 32'h7FC0_0000;
   localparam logic [9:0]  BIAS = 10'd127;
   localparam logic [9:0]  OVF  = 10'd382;

   logic        sign;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;
   logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [47:0] prod;
   logic        norm;
   logic [22:0] man;
   logic        guard, sticky, rnd;
   logic [23:0] man_r;
   logic [9:0]  e_full;

   always_comb begin
      sign   = in1[31] ^ in2[31];
      ea     = in1[30:23];
      eb     = in2[30:23];
      fa     = in1[22:0];
      fb     = in2[22:0];
      a_nan  = (ea == 8'hFF) && (fa != 23'd0);
      b_nan  = (eb == 8'hFF) && (fb != 23'd0);
      a_inf  = (ea == 8'hFF) && (fa == 23'd0);
      b_inf  = (eb == 8'hFF) && (fb == 23'd0);
      a_zero = (ea == 8'd0);
      b_zero = (eb == 8'd0);
      prod   = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};
      norm   = prod[47];
      if (norm) begin
         man    = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
      end else begin
         man    = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      rnd    = guard & (sticky | man[0]);
      man_r  = {1'b0, man} + {23'd0, rnd};
      // Rounding carry-out leaves man_r[22:0] at zero, so only the exponent needs bumping.
      e_full = {2'b00, ea} + {2'b00, eb} + {9'd0, norm} + {9'd0, man_r[23]};

      if (a_nan || b_nan) begin
         out = QNAN;
      end else if (a_inf || b_inf) begin
         out = (a_zero || b_zero) ? QNAN : {sign, 8'hFF, 23'd0};
      end else if (a_zero || b_zero) begin
         out = {sign, 31'd0};
      end else if (e_full >= OVF) begin
         out = {sign, 8'hFF, 23'd0};
      end else if (e_full <= BIAS) begin
         out = {sign, 31'd0};
      end else begin
         out = {sign, 8'(e_full - BIAS), man_r[22:0]};
      end
   end
endmodule

module fp_mul_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*32-1:0]   req_a,
   input  logic [N_REQ*32-1:0]   req_b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_data,
   output logic [ID_W-1:0]       out_id
`ifdef FP_MUL_ARB_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [N_REQ*16-1:0]   stat_grant_cnt,
   output logic [15:0]           stat_stall_cnt
`endif
);
   localparam int unsigned DATA_W = 32;

   logic              a_vld, b_vld;
   logic [ID_W-1:0]   a_id, b_id;
   logic [DATA_W-1:0] op1, op2, mul_out, b_data;
   logic [ID_W-1:0]   rr_ptr, rr_next;
   logic              a_en, b_en;
   logic              grant_any;
   logic [ID_W-1:0]   grant_id;
   logic              accept;

   fp_mul u_fp_mul (
      .in1 (op1),
      .in2 (op2),
      .out (mul_out)
   );

   assign b_en   = !b_vld || out_ready;
   assign a_en   = !a_vld || b_en;
   assign accept = !rst && a_en && grant_any;

   // First valid requester at or after rr_ptr, wrapping.
   always_comb begin
      int unsigned     idx;
      logic [ID_W-1:0] cand;
      idx       = 0;
      cand      = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx  = (32'(rr_ptr) + k) % N_REQ;
         cand = ID_W'(idx);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_id  = cand;
         end
      end
   end

   assign rr_next = (32'(grant_id) == N_REQ - 1) ? '0 : ID_W'(32'(grant_id) + 32'd1);

   always_comb begin
      req_ready = '0;
      if (accept) req_ready[grant_id] = 1'b1;
   end

   // Stage A: operand capture and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_vld  <= 1'b0;
         a_id   <= '0;
         op1    <= '0;
         op2    <= '0;
         rr_ptr <= '0;
      end else if (a_en) begin
         a_vld <= grant_any;
         if (grant_any) begin
            a_id   <= grant_id;
            op1    <= req_a[DATA_W*32'(grant_id) +: DATA_W];
            op2    <= req_b[DATA_W*32'(grant_id) +: DATA_W];
            rr_ptr <= rr_next;
         end
      end
   end

   // Stage B: product capture, drives the output port.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_vld  <= 1'b0;
         b_id   <= '0;
         b_data <= '0;
      end else if (b_en) begin
         b_vld  <= a_vld;
         b_id   <= a_id;
         b_data <= mul_out;
      end
   end

   assign out_valid = b_vld;
   assign out_data  = b_data;
   assign out_id    = b_id;

`ifdef FP_MUL_ARB_STATS_EN
   localparam int unsigned CNT_W = 16;

   // Saturating counters; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         stat_grant_cnt <= '0;
         stat_stall_cnt <= '0;
      end else begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (accept && (32'(grant_id) == i) && (stat_grant_cnt[CNT_W*i +: CNT_W] != '1))
               stat_grant_cnt[CNT_W*i +: CNT_W] <= stat_grant_cnt[CNT_W*i +: CNT_W] + CNT_W'(1);
         end
         if (b_vld && !out_ready && (stat_stall_cnt != '1))
            stat_stall_cnt <= stat_stall_cnt + CNT_W'(1);
      end
   end
`endif
endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed self-checking bench for fp_mul_arbiter (4 requesters); stats checks
// are compiled in when FP_MUL_ARB_STATS_EN is defined.
module tb_fp_mul_arbiter;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*32-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_data;
   logic [1:0]      out_id;
`ifdef FP_MUL_ARB_STATS_EN
   logic            stat_clr;
   logic [N*16-1:0] stat_grant_cnt;
   logic [15:0]     stat_stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   fp_mul_arbiter #(.N_REQ(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
`ifdef FP_MUL_ARB_STATS_EN
      ,
      .stat_clr       (stat_clr),
      .stat_grant_cnt (stat_grant_cnt),
      .stat_stall_cnt (stat_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_valid = '1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b expected 0000", req_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
      checks++;
      if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h expected 00000000", out_data); end
      checks++;
      if (out_id !== 2'd0) begin errors++; $display("FAIL reset_out_id got %0d expected 0", out_id); end
      rst = 1'b0;
      req_valid = '0;
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      set_op(0, 32'h3F80_0000, 32'h4000_0000);
      req_valid = 4'b0001;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b expected 0001", req_ready); end
      tick();
      req_valid = '0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b expected 0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h4000_0000 || out_id !== 2'd0) begin
         errors++; $display("FAIL single_result got v=%b d=%h id=%0d expected v=1 d=40000000 id=0", out_valid, out_data, out_id);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b expected 0", out_valid); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < N; i++) set_op(i, 32'h4000_0000, 32'h4040_0000);
      req_valid = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'h40C0_0000 || out_id !== 2'(k % N)) begin
            errors++;
            $display("FAIL rr_step%0d got v=%b d=%h id=%0d expected v=1 d=40c00000 id=%0d", k, out_valid, out_data, out_id, k % N);
         end
      end
      req_valid = '0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== 2'd1) begin errors++; $display("FAIL rr_tail got v=%b id=%0d expected v=1 id=1", out_valid, out_id); end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got %b expected 0", out_valid); end
   endtask

   task automatic test_sign();
      out_ready = 1'b1;
      set_op(2, 32'h4000_0000, 32'hBF80_0000);
      req_valid = 4'b0100;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL sign_grant got %b expected 0100", req_ready); end
      tick();
      req_valid = '0;
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hC000_0000 || out_id !== 2'd2) begin
         errors++; $display("FAIL sign_result got v=%b d=%h id=%0d expected v=1 d=c0000000 id=2", out_valid, out_data, out_id);
      end
      tick();
   endtask

   task automatic test_backpressure();
      do_reset();
      out_ready = 1'b0;
      set_op(0, 32'h3F80_0000, 32'h4000_0000);
      set_op(1, 32'h4000_0000, 32'h4040_0000);
      set_op(2, 32'h4000_0000, 32'hBF80_0000);
      req_valid = 4'b0111;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0 got %b expected 0001", req_ready); end
      tick();
      req_valid = 4'b0110;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got %b expected 0010", req_ready); end
      tick();
      req_valid = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready%0d got %b expected 0000", k, req_ready); end
         checks++;
         if (out_valid !== 1'b1 || out_data !== 32'h4000_0000 || out_id !== 2'd0) begin
            errors++; $display("FAIL bp_hold%0d got v=%b d=%h id=%0d expected v=1 d=40000000 id=0", k, out_valid, out_data, out_id);
         end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant got %b expected 0100", req_ready); end
      tick();
      req_valid = '0;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h40C0_0000 || out_id !== 2'd1) begin
         errors++; $display("FAIL bp_drain1 got v=%b d=%h id=%0d expected v=1 d=40c00000 id=1", out_valid, out_data, out_id);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hC000_0000 || out_id !== 2'd2) begin
         errors++; $display("FAIL bp_drain2 got v=%b d=%h id=%0d expected v=1 d=c0000000 id=2", out_valid, out_data, out_id);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b expected 0", out_valid); end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) set_op(i, 32'h4000_0000, 32'h4040_0000);
      req_valid = 4'b1111;
      tick();
      tick();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_full got %b expected 1", out_valid); end
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b expected 0000", req_ready); end
      tick();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || out_id !== 2'd0) begin
         errors++; $display("FAIL mid_cleared got v=%b d=%h id=%0d expected v=0 d=00000000 id=0", out_valid, out_data, out_id);
      end
      @(negedge clk);
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_ptr got %b expected 0001", req_ready); end
      tick();
      req_valid = '0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_stale got %b expected 0", out_valid); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h40C0_0000 || out_id !== 2'd0) begin
         errors++; $display("FAIL mid_first got v=%b d=%h id=%0d expected v=1 d=40c00000 id=0", out_valid, out_data, out_id);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_empty got %b expected 0", out_valid); end
   endtask

`ifdef FP_MUL_ARB_STATS_EN
   task automatic test_stats();
      stat_clr = 1'b0;
      do_reset();
      set_op(1, 32'h3F80_0000, 32'h3F80_0000);
      req_valid = 4'b0010;
      for (int k = 0; k < 5; k++) tick();
      req_valid = '0;
      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      out_ready = 1'b1;
      tick();
      tick();
      checks++;
      if (stat_grant_cnt !== 64'h0000_0000_0005_0000) begin
         errors++; $display("FAIL stats_grant got %h expected 0000000000050000", stat_grant_cnt);
      end
      checks++;
      if (stat_stall_cnt !== 16'd3) begin errors++; $display("FAIL stats_stall got %0d expected 3", stat_stall_cnt); end
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      checks++;
      if (stat_grant_cnt !== '0 || stat_stall_cnt !== 16'd0) begin
         errors++; $display("FAIL stats_clr got g=%h s=%0d expected all 0", stat_grant_cnt, stat_stall_cnt);
      end
   endtask
`endif

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      out_ready = 1'b1;
`ifdef FP_MUL_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      test_reset();
      test_single();
      test_round_robin();
      test_sign();
      test_backpressure();
      test_reset_midflight();
`ifdef FP_MUL_ARB_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter that shares one combinational `fp_mul` instance (IN1/IN2 → OUT, FP32) among `N_REQ` requesters. It registers the winning operands, then registers the product, and returns the product on a single tagged output port with valid/ready backpressure. It sits between the fused-FP issue logic and the multiplier datapath, so several units can share one multiplier at one product per cycle.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `ID_W`, default `$clog2(N_REQ)`: width of the requester tag.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input N_REQ: per-requester operand valid.
- `req_ready` output N_REQ: per-requester accept; one-hot or zero.
- `req_a` input N_REQ*32: FP32 operand A; requester i occupies bits [32i+31:32i].
- `req_b` input N_REQ*32: FP32 operand B; same packing as `req_a`.
- `out_valid` output 1: product valid.
- `out_ready` input 1: consumer accepts the product.
- `out_data` output 32: FP32 product.
- `out_id` output ID_W: index of the requester that issued the product.

## Operation
- The block is a two-stage pipeline: stage A holds the operands (`a_vld`, `a_id`, `op1`, `op2`), and stage B holds the result (`b_vld`, `b_id`, `b_data`).
- `fp_mul` is combinational. Its IN1/IN2 are driven by `op1`/`op2`, and its OUT is captured into `b_data`.
- The `out_*` ports are driven directly from stage B.
- Advance enables:
  - `b_en = !b_vld || out_ready`
  - `a_en = !a_vld || b_en`
- Arbitration:
  - When `a_en` is high, the arbiter searches `req_valid` starting at `rr_ptr`, ascending with wrap-around.
  - The first set bit wins, and only that bit of `req_ready` is asserted.
  - When `a_en` is low, all `req_ready` bits are 0.
  - `req_ready` is combinational from `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- An accepted transfer occurs when `req_valid[i] && req_ready[i]`. On an accepted transfer:
  - Stage A loads the operands of requester i, with `a_id=i` and `a_vld=1`.
  - `rr_ptr` becomes `(i+1) mod N_REQ`.
- With no transfer, `rr_ptr` holds. If `a_en` is high and no request is present, `a_vld` clears.
- When `b_en` is high, stage B loads from stage A: `b_vld<=a_vld`, `b_id<=a_id`, `b_data<=OUT`.
- A held request keeps `req_valid` high with stable operands until it is accepted. Operands are sampled only at acceptance.
- Pipeline occupancy takes four states: {A empty, B empty}, {A full, B empty}, {A empty, B full}, {both full}. The block stalls only in {both full} with `out_ready=0`.
- Ordering: products leave in acceptance order. There is no reordering.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_id=0`, `req_ready=0` during reset, `a_vld=0`, `rr_ptr=0`, and all statistics counters 0.
- Reset mid-operation discards all in-flight products; no output handshake follows.
- Latency: an operand accepted at edge t appears on `out_valid`/`out_data` after edge t+1, provided `out_ready` is held high. That is 2 cycles from request-visible to result-visible.
- Throughput: 1 accept per cycle while `out_ready=1`.
- Backpressure: with `out_valid=1` and `out_ready=0`:
  - `out_data`/`out_id` hold stable.
  - Stage A can still fill once.
  - After that, `req_ready` is all zero until `out_ready` returns.
- When out is accepted and a new request arrives in the same cycle, both happen at that edge. There is no bubble.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0. No requester waits more than N_REQ-1 grants.

## Configuration
- `FP_MUL_ARB_STATS_EN` defined adds statistics:
  - Inputs: `stat_clr` (1).
  - Outputs: `stat_grant_cnt` (N_REQ*16, per-requester accepted count) and `stat_stall_cnt` (16, counts cycles with `out_valid && !out_ready`).
  - Counters saturate at 0xFFFF.
  - `stat_clr` clears them synchronously and takes priority over an increment in the same cycle.
- `FP_MUL_ARB_STATS_EN` undefined: these ports and counters are absent. Arbitration and datapath behaviour are identical in both builds.

## Test plan
- Single request: req0 a=0x3F800000 (1.0), b=0x40000000 (2.0), `out_ready=1` → `out_valid` 2 cycles later with `out_data=0x40000000` and `out_id=0`.
- Round-robin: all 4 requesters held valid with `out_ready=1`, req i a=0x40000000, b=0x40400000 → outputs 0x40C00000 each cycle with `out_id` sequence 0,1,2,3,0.
- Sign handling: req2 a=0x40000000 (2.0), b=0xBF800000 (-1.0) → `out_data=0xC0000000` and `out_id=2`.
- Backpressure: `out_ready=0` while 3 requests are pending → exactly 2 accepts, `out_valid` held with stable data, then `req_ready=0`. Releasing `out_ready` drains the results in order with no loss or duplication.
- Reset mid-flight: assert `rst` for 1 cycle with both stages full → the next cycle shows `out_valid=0`, `out_data=0`, and `rr_ptr` restarting at requester 0.
- Stats (`FP_MUL_ARB_STATS_EN` defined): 5 grants to req1 plus 3 stall cycles → `stat_grant_cnt[1]=5` and `stat_stall_cnt=3`. A `stat_clr` pulse then brings all counters to 0.
